// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core: FSM state encoding,
// BCD digit limits and the bit offsets of each digit within disp.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StLap   = 2'd3
    } state_e;

    localparam logic [3:0] DigitMax9 = 4'd9;
    localparam logic [3:0] DigitMax5 = 4'd5;

    localparam int unsigned DispWidth = 24;

    localparam int unsigned CsLoOff = 0;
    localparam int unsigned CsHiOff = 4;
    localparam int unsigned SLoOff  = 8;
    localparam int unsigned SHiOff  = 12;
    localparam int unsigned MLoOff  = 16;
    localparam int unsigned MHiOff  = 20;

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the stopwatch count, rolling over after MAX.
// carry is combinational so the whole cascade settles within one cycle.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] MAX = DigitMax9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] cnt_q;

    // The >= rollover keeps the digit inside 0..MAX even from a corrupted value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 4'd0;
        end else if (clr) begin
            cnt_q <= 4'd0;
        end else if (inc) begin
            if (cnt_q >= MAX) begin
                cnt_q <= 4'd0;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    assign q     = cnt_q;
    assign carry = inc && (cnt_q == MAX);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: mm:ss.cc BCD counter with run / pause / clear control.
// Define STOPWATCH_LAP_EN to build the lap-hold state and lap register.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter bit OVF_STOP = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 start_stop,
    input  logic                 clear,
    input  logic                 lap,
    output logic [DispWidth-1:0] disp,
    output logic                 running,
    output logic                 lap_active,
    output logic                 ovf
);

    state_e state_q, state_d;

    logic count_en, clear_hit, all_max, stop_hit, ovf_set, ovf_q;
    logic [3:0] cs_lo, cs_hi, s_lo, s_hi, m_lo, m_hi;
    logic inc_cs_lo, inc_cs_hi, inc_s_lo, inc_s_hi, inc_m_lo, inc_m_hi;
    logic carry_cs_lo, carry_cs_hi, carry_s_lo, carry_s_hi, carry_m_lo, carry_m_hi;
    logic [DispWidth-1:0] live;

    assign count_en  = tick && ((state_q == StRun) || (state_q == StLap));
    assign clear_hit = clear && ((state_q == StIdle) || (state_q == StPause));

    assign all_max = (cs_lo == DigitMax9) && (cs_hi == DigitMax9) &&
                     (s_lo == DigitMax9) && (s_hi == DigitMax5) &&
                     (m_lo == DigitMax9) && (m_hi == DigitMax5);

    // In halt mode the tick at 59:59.99 is swallowed so every digit holds.
    assign stop_hit = OVF_STOP && count_en && all_max;
    assign ovf_set  = OVF_STOP ? stop_hit : carry_m_hi;

    assign inc_cs_lo = count_en && !stop_hit;
    assign inc_cs_hi = carry_cs_lo;
    assign inc_s_lo  = carry_cs_hi;
    assign inc_s_hi  = carry_s_lo;
    assign inc_m_lo  = carry_s_hi;
    assign inc_m_hi  = carry_m_lo;

    bcd_digit #(.MAX(DigitMax9)) u_cs_lo (
        .clk(clk), .rst(rst), .inc(inc_cs_lo), .clr(clear_hit), .q(cs_lo), .carry(carry_cs_lo)
    );
    bcd_digit #(.MAX(DigitMax9)) u_cs_hi (
        .clk(clk), .rst(rst), .inc(inc_cs_hi), .clr(clear_hit), .q(cs_hi), .carry(carry_cs_hi)
    );
    bcd_digit #(.MAX(DigitMax9)) u_s_lo (
        .clk(clk), .rst(rst), .inc(inc_s_lo), .clr(clear_hit), .q(s_lo), .carry(carry_s_lo)
    );
    bcd_digit #(.MAX(DigitMax5)) u_s_hi (
        .clk(clk), .rst(rst), .inc(inc_s_hi), .clr(clear_hit), .q(s_hi), .carry(carry_s_hi)
    );
    bcd_digit #(.MAX(DigitMax9)) u_m_lo (
        .clk(clk), .rst(rst), .inc(inc_m_lo), .clr(clear_hit), .q(m_lo), .carry(carry_m_lo)
    );
    bcd_digit #(.MAX(DigitMax5)) u_m_hi (
        .clk(clk), .rst(rst), .inc(inc_m_hi), .clr(clear_hit), .q(m_hi), .carry(carry_m_hi)
    );

    always_comb begin
        live = '0;
        live[CsLoOff +: 4] = cs_lo;
        live[CsHiOff +: 4] = cs_hi;
        live[SLoOff +: 4]  = s_lo;
        live[SHiOff +: 4]  = s_hi;
        live[MLoOff +: 4]  = m_lo;
        live[MHiOff +: 4]  = m_hi;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (clear_hit) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear outranks start_stop, which outranks lap; ignored commands do not block.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StPause: begin
                if (clear) begin
                    state_d = StIdle;
                end else if (start_stop) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (stop_hit || start_stop) begin
                    state_d = StPause;
                end
`ifdef STOPWATCH_LAP_EN
                else if (lap) begin
                    state_d = StLap;
                end
`endif
            end
`ifdef STOPWATCH_LAP_EN
            StLap: begin
                if (stop_hit || start_stop) begin
                    state_d = StPause;
                end else if (lap) begin
                    state_d = StRun;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

`ifdef STOPWATCH_LAP_EN
    logic [DispWidth-1:0] lap_q;

    // Captures the pre-increment value, so a same-edge tick is not included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_q <= '0;
        end else if ((state_q == StRun) && (state_d == StLap)) begin
            lap_q <= live;
        end
    end
`else
    logic unused_lap;
    assign unused_lap = lap;
`endif

    always_comb begin
        disp       = live;
        running    = (state_q == StRun) || (state_q == StLap);
        lap_active = 1'b0;
        ovf        = ovf_q;
`ifdef STOPWATCH_LAP_EN
        if (state_q == StLap) begin
            disp       = lap_q;
            lap_active = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: a halt-on-overflow and a wrap-on-overflow
// instance share stimulus; a vector table drives the main scenarios.
module tb_stopwatch_core;
    import stopwatch_pkg::*;

`ifdef STOPWATCH_LAP_EN
    localparam bit LapOn = 1'b1;
`else
    localparam bit LapOn = 1'b0;
`endif

    logic        clk, rst, tick, start_stop, clear, lap;
    logic [23:0] disp_s, disp_w;
    logic        run_s, run_w, la_s, la_w, ovf_s, ovf_w;

    int checks = 0;
    int errors = 0;

    stopwatch_core #(.OVF_STOP(1'b1)) dut_stop (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
        .disp(disp_s), .running(run_s), .lap_active(la_s), .ovf(ovf_s)
    );

    stopwatch_core #(.OVF_STOP(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
        .disp(disp_w), .running(run_w), .lap_active(la_w), .ovf(ovf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          ss, clr, lp, tk;
        int unsigned n;
        logic [23:0] disp;
        bit          run, la, ov;
        state_e      st;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string name, input bit ss, input bit clr, input bit lp,
                       input bit tk, input int unsigned n, input logic [23:0] d,
                       input bit run, input bit la, input state_e st);
        vec_t v;
        v.name = name; v.ss = ss; v.clr = clr; v.lp = lp; v.tk = tk; v.n = n;
        v.disp = d; v.run = run; v.la = la; v.ov = 1'b0; v.st = st;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit s, input bit c, input bit l, input bit t);
        start_stop = s; clear = c; lap = l; tick = t;
        @(posedge clk);
        #1;
        start_stop = 1'b0; clear = 1'b0; lap = 1'b0; tick = 1'b0;
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        #12;
        chk("rst.disp", 32'(disp_s), 32'h0);
        chk("rst.running", 32'(run_s), 32'h0);
        chk("rst.lap_active", 32'(la_s), 32'h0);
        chk("rst.ovf", 32'(ovf_s), 32'h0);
        chk("rst.state", 32'(dut_stop.state_q), 32'(StIdle));
        #5 rst = 1'b1;

        // name, ss, clr, lap, tick, extra ticks, disp, running, lap_active, state
        add("start",       1, 0, 0, 1, 0,    24'h000000, 1, 0, StRun);
        add("tick20",      0, 0, 0, 1, 19,   24'h000020, 1, 0, StRun);
        add("lap_in",      0, 0, 1, 0, 0,    24'h000020, 1, LapOn,
            LapOn ? StLap : StRun);
        add("lap_hold30",  0, 0, 0, 1, 29,   LapOn ? 24'h000020 : 24'h000050, 1, LapOn,
            LapOn ? StLap : StRun);
        add("lap_out",     0, 0, 1, 0, 0,    24'h000050, 1, 0, StRun);
        add("lap_in2",     0, 0, 1, 0, 0,    24'h000050, 1, LapOn,
            LapOn ? StLap : StRun);
        add("ss_from_lap", 1, 0, 0, 1, 0,    24'h000051, 0, 0, StPause);
        add("resume",      1, 0, 0, 1, 0,    24'h000051, 1, 0, StRun);
        add("lap_tick",    0, 0, 1, 1, 0,    LapOn ? 24'h000051 : 24'h000052, 1, LapOn,
            LapOn ? StLap : StRun);
        add("lap_out_tk",  0, 0, 1, 1, 0,    24'h000053, 1, 0, StRun);
        add("ss_over_lap", 1, 0, 1, 0, 0,    24'h000053, 0, 0, StPause);
        add("clr_ss_p",    1, 1, 0, 0, 0,    24'h000000, 0, 0, StIdle);
        add("start2",      1, 0, 0, 1, 0,    24'h000000, 1, 0, StRun);
        add("tick149",     0, 0, 0, 1, 148,  24'h000149, 1, 0, StRun);
        add("stop150",     1, 0, 0, 1, 0,    24'h000150, 0, 0, StPause);
        add("pause_ticks", 0, 0, 0, 1, 9,    24'h000150, 0, 0, StPause);
        add("lap_pause",   0, 0, 1, 1, 0,    24'h000150, 0, 0, StPause);
        add("resume_nc",   1, 0, 0, 1, 0,    24'h000150, 1, 0, StRun);
        add("clr_in_run",  0, 1, 0, 1, 0,    24'h000151, 1, 0, StRun);
        add("to_300",      0, 0, 0, 1, 148,  24'h000300, 1, 0, StRun);
        add("pause300",    1, 0, 0, 0, 0,    24'h000300, 0, 0, StPause);
        add("clr_ss_300",  1, 1, 0, 0, 0,    24'h000000, 0, 0, StIdle);
        add("clr_idle",    0, 1, 0, 0, 0,    24'h000000, 0, 0, StIdle);
        add("start3",      1, 0, 0, 0, 0,    24'h000000, 1, 0, StRun);
        add("to_5999",     0, 0, 0, 1, 5998, 24'h005999, 1, 0, StRun);
        add("min_carry",   0, 0, 0, 1, 0,    24'h010000, 1, 0, StRun);
        add("to_15999",    0, 0, 0, 1, 5998, 24'h015999, 1, 0, StRun);

        foreach (vq[i]) begin
            step(vq[i].ss, vq[i].clr, vq[i].lp, vq[i].tk);
            repeat (vq[i].n) step(1'b0, 1'b0, 1'b0, 1'b1);
            chk({vq[i].name, ".disp"}, 32'(disp_s), 32'(vq[i].disp));
            chk({vq[i].name, ".running"}, 32'(run_s), 32'(vq[i].run));
            chk({vq[i].name, ".lap_active"}, 32'(la_s), 32'(vq[i].la));
            chk({vq[i].name, ".ovf"}, 32'(ovf_s), 32'(vq[i].ov));
            chk({vq[i].name, ".state"}, 32'(dut_stop.state_q), 32'(vq[i].st));
            chk({vq[i].name, ".wrap_disp"}, 32'(disp_w), 32'(vq[i].disp));
        end

        // Jump both instances from 01:59.99 to 59:59.99 by loading the minute digits.
        force dut_stop.u_m_hi.cnt_q = 4'd5;
        force dut_stop.u_m_lo.cnt_q = 4'd9;
        force dut_wrap.u_m_hi.cnt_q = 4'd5;
        force dut_wrap.u_m_lo.cnt_q = 4'd9;
        #1;
        release dut_stop.u_m_hi.cnt_q;
        release dut_stop.u_m_lo.cnt_q;
        release dut_wrap.u_m_hi.cnt_q;
        release dut_wrap.u_m_lo.cnt_q;
        #1;
        chk("preload.stop", 32'(disp_s), 32'h595999);
        chk("preload.wrap", 32'(disp_w), 32'h595999);

        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf_stop.disp", 32'(disp_s), 32'h595999);
        chk("ovf_stop.ovf", 32'(ovf_s), 32'h1);
        chk("ovf_stop.state", 32'(dut_stop.state_q), 32'(StPause));
        chk("ovf_stop.running", 32'(run_s), 32'h0);
        chk("ovf_wrap.disp", 32'(disp_w), 32'h000000);
        chk("ovf_wrap.ovf", 32'(ovf_w), 32'h1);
        chk("ovf_wrap.state", 32'(dut_wrap.state_q), 32'(StRun));

        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("post_ovf.stop_disp", 32'(disp_s), 32'h595999);
        chk("post_ovf.wrap_disp", 32'(disp_w), 32'h000001);
        chk("post_ovf.wrap_ovf", 32'(ovf_w), 32'h1);

        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("clr_ovf.stop_disp", 32'(disp_s), 32'h000000);
        chk("clr_ovf.stop_ovf", 32'(ovf_s), 32'h0);
        chk("clr_ovf.stop_state", 32'(dut_stop.state_q), 32'(StIdle));
        chk("clr_run.wrap_ovf", 32'(ovf_w), 32'h1);
        chk("clr_run.wrap_disp", 32'(disp_w), 32'h000001);

        // Asynchronous reset in the middle of a run, between clock edges.
        step(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("pre_rst.disp", 32'(disp_s), 32'h000005);
        #3 rst = 1'b0;
        #1;
        chk("async_rst.disp", 32'(disp_s), 32'h0);
        chk("async_rst.running", 32'(run_s), 32'h0);
        chk("async_rst.lap_active", 32'(la_s), 32'h0);
        chk("async_rst.ovf", 32'(ovf_s), 32'h0);
        chk("async_rst.wrap_disp", 32'(disp_w), 32'h0);
        chk("async_rst.wrap_ovf", 32'(ovf_w), 32'h0);
        #2 rst = 1'b1;

        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("after_rst.disp", 32'(disp_s), 32'h0);
        chk("after_rst.state", 32'(dut_stop.state_q), 32'(StIdle));
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("after_rst.start", 32'(dut_stop.state_q), 32'(StRun));
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("after_rst.count", 32'(disp_s), 32'h000001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
